scpad_swizzle_seq: RTL

Tile-walk sequencer for the scratchpad swizzle unit. Accepts one tile-access command (base address, tile dimensions, row/column orientation) and steps the swizzle interface through every slice of the tile, one slice per cycle. Each slice's crossbar descriptor is captured into a registered, back-pressurable output stage feeding the bank crossbar, and `done` is pulsed when the last slice is accepted.

---
 rtl/scpad_pkg.sv | 19 +
 rtl/scpad_swizzle_seq_if.sv | 25 ++
 rtl/scpad_out_reg.sv | 50 +++++
 rtl/scpad_swizzle_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/scpad_pkg.sv
// Shared scratchpad types and widths for the swizzle tile-walk sequencer.
package scpad_pkg;

  localparam int SCPAD_ADDR_WIDTH = 16;
  localparam int MAX_DIM_WIDTH    = 5;

  typedef struct packed {
    logic [7:0]               bank_mask;
    logic [MAX_DIM_WIDTH-1:0] rot;
  } xbar_desc_t;

  typedef enum logic [1:0] {
    SWZ_IDLE  = 2'd0,
    SWZ_WALK  = 2'd1,
    SWZ_FLUSH = 2'd2,
    SWZ_DONE  = 2'd3
  } swz_seq_state_t;

endpackage

// File: rtl/scpad_swizzle_seq_if.sv
// Drive bundle between the tile-walk sequencer and the combinational swizzle unit.
interface scpad_swizzle_seq_if
  import scpad_pkg::*;
#(
  parameter int ADDR_W = SCPAD_ADDR_WIDTH,
  parameter int DIM_W  = MAX_DIM_WIDTH
);
  logic              sw_row_or_col;
  logic [ADDR_W-1:0] sw_spad_addr;
  logic [DIM_W-1:0]  sw_num_rows;
  logic [DIM_W-1:0]  sw_num_cols;
  logic [DIM_W-1:0]  sw_row_id;
  logic [DIM_W-1:0]  sw_col_id;
  xbar_desc_t        sw_xbar_desc;

  modport master (
    output sw_row_or_col, sw_spad_addr, sw_num_rows, sw_num_cols, sw_row_id, sw_col_id,
    input  sw_xbar_desc
  );

  modport slave (
    input  sw_row_or_col, sw_spad_addr, sw_num_rows, sw_num_cols, sw_row_id, sw_col_id,
    output sw_xbar_desc
  );
endinterface

// File: rtl/scpad_out_reg.sv
// Valid/ready output register holding one crossbar descriptor beat.
module scpad_out_reg
  import scpad_pkg::*;
#(
  parameter int DIM_W = MAX_DIM_WIDTH
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clear,
  input  logic             load,
  input  xbar_desc_t       load_desc,
  input  logic [DIM_W-1:0] load_idx,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             out_valid,
  output xbar_desc_t       out_xbar_desc,
  output logic [DIM_W-1:0] out_idx,
  output logic             out_last
);
  logic             valid_reg;
  xbar_desc_t       desc_reg;
  logic [DIM_W-1:0] idx_reg;
  logic             last_reg;

  // clear wins over load; an accepted beat drops valid unless refilled
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_reg <= 1'b0;
      desc_reg  <= '0;
      idx_reg   <= '0;
      last_reg  <= 1'b0;
    end else begin
      if (clear) begin
        valid_reg <= 1'b0;
      end else if (load) begin
        valid_reg <= 1'b1;
        desc_reg  <= load_desc;
        idx_reg   <= load_idx;
        last_reg  <= load_last;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid     = valid_reg;
  assign out_xbar_desc = desc_reg;
  assign out_idx       = idx_reg;
  assign out_last      = last_reg;
endmodule

// File: rtl/scpad_swizzle_seq.sv
// Tile-walk sequencer: steps the swizzle unit through each slice of a tile, one per cycle.
module scpad_swizzle_seq
  import scpad_pkg::*;
#(
  parameter int ADDR_W = SCPAD_ADDR_WIDTH,
  parameter int DIM_W  = MAX_DIM_WIDTH
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_row_or_col,
  input  logic [ADDR_W-1:0]   req_base_addr,
  input  logic [DIM_W-1:0]    req_num_rows,
  input  logic [DIM_W-1:0]    req_num_cols,
  input  logic                abort,
  scpad_swizzle_seq_if.master sw,
  output logic                out_valid,
  input  logic                out_ready,
  output xbar_desc_t          out_xbar_desc,
  output logic [DIM_W-1:0]    out_idx,
  output logic                out_last,
  output logic                done
);
  localparam logic [1:0] S_IDLE  = SWZ_IDLE;
  localparam logic [1:0] S_WALK  = SWZ_WALK;
  localparam logic [1:0] S_FLUSH = SWZ_FLUSH;
  localparam logic [1:0] S_DONE  = SWZ_DONE;

  logic [1:0]        state_reg, state_next;
  logic              row_or_col_reg, row_or_col_next;
  logic [ADDR_W-1:0] base_addr_reg, base_addr_next;
  logic [DIM_W-1:0]  num_rows_reg, num_rows_next;
  logic [DIM_W-1:0]  num_cols_reg, num_cols_next;
  logic [DIM_W-1:0]  idx_reg, idx_next;
  logic              done_reg;
  logic [DIM_W-1:0]  slice_cnt, req_slice_cnt;
  logic              is_last, advance, load;

  assign slice_cnt     = row_or_col_reg ? num_cols_reg : num_rows_reg;
  assign req_slice_cnt = req_row_or_col ? req_num_cols : req_num_rows;
  assign is_last       = (idx_reg == slice_cnt - DIM_W'(1));
  assign advance       = (state_reg == S_WALK) && (!out_valid || out_ready);
  assign load          = advance && !abort;

  always_comb begin
    state_next      = state_reg;
    row_or_col_next = row_or_col_reg;
    base_addr_next  = base_addr_reg;
    num_rows_next   = num_rows_reg;
    num_cols_next   = num_cols_reg;
    idx_next        = idx_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (req_valid) begin
          row_or_col_next = req_row_or_col;
          base_addr_next  = req_base_addr;
          num_rows_next   = req_num_rows;
          num_cols_next   = req_num_cols;
          idx_next        = '0;
          // an empty tile skips WALK; FLUSH with nothing pending adds the cycle that keeps done timing uniform
          state_next      = (req_slice_cnt == '0) ? S_FLUSH : S_WALK;
        end
        S_WALK: if (advance) begin
          idx_next = idx_reg + DIM_W'(1);
          if (is_last) state_next = S_FLUSH;
        end
        S_FLUSH: if (!out_valid || out_ready) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= S_IDLE;
      row_or_col_reg <= 1'b0;
      base_addr_reg  <= '0;
      num_rows_reg   <= '0;
      num_cols_reg   <= '0;
      idx_reg        <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_or_col_reg <= row_or_col_next;
      base_addr_reg  <= base_addr_next;
      num_rows_reg   <= num_rows_next;
      num_cols_reg   <= num_cols_next;
      idx_reg        <= idx_next;
      done_reg       <= (state_next == S_DONE);
    end
  end

  assign req_ready        = (state_reg == S_IDLE);
  assign done             = done_reg;
  assign sw.sw_row_or_col = row_or_col_reg;
  assign sw.sw_spad_addr  = base_addr_reg;
  assign sw.sw_num_rows   = num_rows_reg;
  assign sw.sw_num_cols   = num_cols_reg;
  assign sw.sw_row_id     = row_or_col_reg ? '0 : idx_reg;
  assign sw.sw_col_id     = row_or_col_reg ? idx_reg : '0;

  scpad_out_reg #(.DIM_W(DIM_W)) u_out_reg (
    .CLK           (CLK),
    .nRST          (nRST),
    .clear         (abort),
    .load          (load),
    .load_desc     (sw.sw_xbar_desc),
    .load_idx      (idx_reg),
    .load_last     (is_last),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_xbar_desc (out_xbar_desc),
    .out_idx       (out_idx),
    .out_last      (out_last)
  );
endmodule
